genie_merge_arb: RTL and testbench
==================================

GENIE_MERGE_ARB -- requirements
Module: genie_merge_arb

Interface
REQ-001 The block SHALL expose parameter NI, default 2, as the number of competing inputs (legal range 2..16).
REQ-002 The block SHALL expose parameter WIDTH, default 1, as the payload width per input (legal range 1 or more).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  reset, synchronous and active-low; asserted when 0.
REQ-005 Port: i_data  input  [NI-1:0][WIDTH-1:0]  per-input payload.
REQ-006 Port: i_valid  input  NI  per-input beat valid.
REQ-007 Port: i_eop  input  NI  per-input end-of-packet flag, qualified by i_valid.
REQ-008 Port: o_ready  output  NI  per-input backpressure.
REQ-009 Port: o_valid  output  1  merged beat valid.
REQ-010 Port: o_data  output  WIDTH  merged payload.
REQ-011 Port: o_eop  output  1  merged end-of-packet.
REQ-012 Port: i_ready  input  1  downstream ready.
REQ-013 Port: o_grant  output  NI  one-hot current grant, or all-zero when no grant.

Function
REQ-014 The block SHALL merge inputs that may compete, using packet-atomic round-robin arbitration.
REQ-015 A transfer SHALL occur on input i in a cycle when i_valid[i], o_grant[i] and i_ready are all 1.
REQ-016 State machine: IDLE (no packet in flight) and LOCKED (packet in flight on register lock_idx).
REQ-017 In IDLE, the grant SHALL be combinational with zero cycle latency.
  - Grant goes to the first asserted i_valid, scanning from index rr_ptr upward, mod NI.
  - o_grant SHALL be zero if no i_valid is asserted.
REQ-018 In LOCKED, o_grant SHALL be one-hot at lock_idx regardless of other i_valid bits.
REQ-019 Datapath outputs:
  - o_valid = i_valid[g], o_data = i_data[g], o_eop = i_eop[g], where g is the granted index.
  - With no grant: o_valid = 0, and o_data and o_eop SHALL be 0.
REQ-020 o_ready[i] SHALL equal i_ready AND o_grant[i]; ungranted inputs SHALL see o_ready = 0.
REQ-021 IDLE to LOCKED SHALL happen when a transfer occurs with o_eop = 0; lock_idx is set to the granted index.
REQ-022 IDLE stays IDLE when a transfer occurs with o_eop = 1 (single-beat packet); rr_ptr SHALL update per REQ-024.
REQ-023 LOCKED to IDLE SHALL happen when a transfer occurs with o_eop = 1.
REQ-024 On every transfer with o_eop = 1, rr_ptr SHALL become (granted index + 1) mod NI.
  - rr_ptr SHALL be unchanged otherwise.
  - rr_ptr wraps from NI-1 to 0.
REQ-025 Non-transfer cycles SHALL leave state unchanged; this includes valid with i_ready = 0, and i_ready with valid = 0.
  - A locked input may drop i_valid mid-packet; the lock SHALL hold and other inputs stay blocked.
REQ-026 The grant SHALL NOT change while o_valid = 1 and i_ready = 0 (no retraction of an offered beat).
  - Exception: in IDLE, a higher-priority input newly asserting valid during a stall SHALL NOT steal the grant.
  - To enforce this, IDLE SHALL register the offered index in hold_idx and honour it while stalled.
REQ-027 rr_ptr and lock_idx width SHALL be clog2(NI) bits; the NI-way mux SHALL be a one-hot AND-OR.
REQ-028 Fairness: any continuously valid input SHALL be granted within NI-1 packets of other inputs.

Reset
REQ-029 While reset = 0 at a clk edge, the block SHALL enter IDLE.
  - rr_ptr = 0, lock_idx = 0, hold flag cleared.
REQ-030 While reset = 0, o_ready, o_grant, o_valid, o_data and o_eop SHALL all be 0.
REQ-031 Reset asserted mid-packet SHALL abandon the lock; the first cycle after release arbitrates from rr_ptr = 0.

Verification (NI=3, WIDTH=8)
REQ-032 All inputs send 1-beat packets (eop = 1), i_ready = 1 -> grants cycle 0,1,2,0,1,2 on consecutive cycles, one beat per cycle.
REQ-033 Input 1 sends a 3-beat packet A1,A2,A3 while inputs 0 and 2 are valid throughout -> o_data = A1,A2,A3 contiguous, o_ready[0] = o_ready[2] = 0 throughout, next grant goes to input 2.
REQ-034 Input 0 is offered with i_ready = 0 for 4 cycles and input 2 raises valid in cycle 2 -> o_grant stays 3'b001 and o_data is stable for all 4 cycles.
REQ-035 Input 2 is locked after beat 1, drops i_valid for 3 cycles, then sends eop -> o_valid = 0 during the gap, inputs 0 and 1 stay blocked, then rr_ptr = 0.
REQ-036 Reset is asserted mid-packet on input 1 -> all outputs are 0 during reset; after release with all inputs valid, input 0 is granted first.
REQ-037 Random valid/eop/ready traffic for 10k cycles -> per-input packets are never interleaved on the output, and no input waits more than 2 packets.

Source files
------------

// File: rtl/genie_merge_arb.sv
// Packet-atomic round-robin merge of NI valid/ready streams onto one output.
// The grant is combinational while idle and pinned to the packet owner until its eop beat leaves.
module genie_merge_arb #(
    parameter int NI    = 2,
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NI-1:0][WIDTH-1:0] i_data,
    input  logic [NI-1:0]            i_valid,
    input  logic [NI-1:0]            i_eop,
    output logic [NI-1:0]            o_ready,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_eop,
    input  logic                     i_ready,
    output logic [NI-1:0]            o_grant
);

    localparam int PW = $clog2(NI);
    localparam int SW = PW + 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(NI - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]    state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] lock_idx;
    logic [PW-1:0] hold_idx;
    logic          hold_vld;

    logic [NI-1:0] rot_valid;
    logic [SW-1:0] scan_sum;
    logic [PW-1:0] scan_idx;
    logic          scan_found;
    logic [PW-1:0] gnt_idx;
    logic          gnt_vld;
    logic [PW-1:0] nxt_ptr;
    logic          xfer;

    // Rotate valids so bit k is input (rr_ptr + k) mod NI; the first set bit wins.
    always_comb begin
        rot_valid  = NI'({i_valid, i_valid} >> rr_ptr);
        scan_found = 1'b0;
        scan_idx   = '0;
        scan_sum   = '0;
        for (int k = 0; k < NI; k++) begin
            if (!scan_found && rot_valid[k]) begin
                scan_found = 1'b1;
                scan_sum   = {1'b0, rr_ptr} + SW'(k);
                if (scan_sum >= SW'(NI)) begin
                    scan_sum = scan_sum - SW'(NI);
                end
                scan_idx = scan_sum[PW-1:0];
            end
        end
    end

    // A stalled idle offer is held so a newly valid higher-priority input cannot retract it.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (!reset) begin
            gnt_vld = 1'b0;
        end else if (state == ST_LOCKED) begin
            gnt_vld = 1'b1;
            gnt_idx = lock_idx;
        end else if (hold_vld) begin
            gnt_vld = 1'b1;
            gnt_idx = hold_idx;
        end else begin
            gnt_vld = scan_found;
            gnt_idx = scan_idx;
        end
    end

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < NI; i++) begin
            o_grant[i] = gnt_vld && (gnt_idx == PW'(i));
        end
    end

    always_comb begin
        o_data = '0;
        for (int i = 0; i < NI; i++) begin
            o_data = o_data | ({WIDTH{o_grant[i]}} & i_data[i]);
        end
    end

    assign o_valid = |(o_grant & i_valid);
    assign o_eop   = |(o_grant & i_eop);
    assign o_ready = {NI{i_ready}} & o_grant;
    assign xfer    = o_valid && i_ready;
    assign nxt_ptr = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
            hold_idx <= '0;
            hold_vld <= 1'b0;
        end else begin
            if (xfer && o_eop) begin
                rr_ptr <= nxt_ptr;
            end
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        hold_vld <= 1'b0;
                        if (!o_eop) begin
                            state    <= ST_LOCKED;
                            lock_idx <= gnt_idx;
                        end
                    end else if (o_valid) begin
                        hold_vld <= 1'b1;
                        hold_idx <= gnt_idx;
                    end else begin
                        hold_vld <= 1'b0;
                    end
                end
                default: begin
                    if (xfer && o_eop) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_genie_merge_arb.sv
// Directed bench for genie_merge_arb with NI=3, WIDTH=8.
module tb_genie_merge_arb;

    localparam int NI    = 3;
    localparam int WIDTH = 8;

    logic                     clk;
    logic                     reset;
    logic [NI-1:0][WIDTH-1:0] i_data;
    logic [NI-1:0]            i_valid;
    logic [NI-1:0]            i_eop;
    logic [NI-1:0]            o_ready;
    logic                     o_valid;
    logic [WIDTH-1:0]         o_data;
    logic                     o_eop;
    logic                     i_ready;
    logic [NI-1:0]            o_grant;

    int vectors     = 0;
    int miscompares = 0;

    genie_merge_arb #(.NI(NI), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_eop   (i_eop),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_eop   (o_eop),
        .i_ready (i_ready),
        .o_grant (o_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [NI-1:0] g, input logic v,
                             input logic [WIDTH-1:0] d, input logic e, input logic [NI-1:0] r);
        chk({tag, ".grant"}, 32'(o_grant), 32'(g));
        chk({tag, ".valid"}, 32'(o_valid), 32'(v));
        chk({tag, ".data"},  32'(o_data),  32'(d));
        chk({tag, ".eop"},   32'(o_eop),   32'(e));
        chk({tag, ".ready"}, 32'(o_ready), 32'(r));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        i_ready = 1'b1;
        i_valid = 3'b111;
        i_eop   = 3'b111;
        i_data  = {8'hA2, 8'hA1, 8'hA0};
        #1 check_out("rst_pre", 3'b000, 1'b0, 8'h00, 1'b0, 3'b000);
        step();
        check_out("rst_edge", 3'b000, 1'b0, 8'h00, 1'b0, 3'b000);
        reset = 1'b1;

        // single-beat packets from all inputs rotate 0,1,2,0,1,2
        for (int n = 0; n < 6; n++) begin
            #1 check_out("rr_cycle", 3'b001 << (n % 3), 1'b1, 8'hA0 + 8'(n % 3), 1'b1, 3'b001 << (n % 3));
            step();
        end

        i_valid = 3'b000;
        #1 check_out("no_valid", 3'b000, 1'b0, 8'h00, 1'b0, 3'b000);
        step();

        i_valid = 3'b001;
        #1 check_out("solo0", 3'b001, 1'b1, 8'hA0, 1'b1, 3'b001);
        step();

        // three-beat packet on input 1 while 0 and 2 stay valid
        i_valid = 3'b111;
        i_eop   = 3'b101;
        i_data  = {8'hC2, 8'hB1, 8'hC0};
        #1 check_out("pkt_b1", 3'b010, 1'b1, 8'hB1, 1'b0, 3'b010);
        step();
        i_data[1] = 8'hB2;
        #1 check_out("pkt_b2", 3'b010, 1'b1, 8'hB2, 1'b0, 3'b010);
        step();
        i_data[1] = 8'hB3;
        i_eop     = 3'b111;
        #1 check_out("pkt_b3", 3'b010, 1'b1, 8'hB3, 1'b1, 3'b010);
        step();
        #1 check_out("pkt_next", 3'b100, 1'b1, 8'hC2, 1'b1, 3'b100);
        step();

        i_valid = 3'b001;
        #1 check_out("pre_stall", 3'b001, 1'b1, 8'hC0, 1'b1, 3'b001);
        step();

        // stalled offer on input 0; input 2 would otherwise win from rr_ptr=1
        i_ready   = 1'b0;
        i_data[0] = 8'hD0;
        #1 check_out("stall_c1", 3'b001, 1'b1, 8'hD0, 1'b1, 3'b000);
        step();
        i_valid = 3'b101;
        for (int n = 0; n < 3; n++) begin
            #1 check_out("stall_cn", 3'b001, 1'b1, 8'hD0, 1'b1, 3'b000);
            step();
        end
        i_ready = 1'b1;
        #1 check_out("stall_rel", 3'b001, 1'b1, 8'hD0, 1'b1, 3'b001);
        step();
        #1 check_out("stall_next", 3'b100, 1'b1, 8'hC2, 1'b1, 3'b100);
        step();

        // input 2 locks, then goes quiet for three cycles
        i_valid   = 3'b100;
        i_eop     = 3'b011;
        i_data[2] = 8'hE1;
        #1 check_out("gap_b1", 3'b100, 1'b1, 8'hE1, 1'b0, 3'b100);
        step();
        i_valid = 3'b011;
        for (int n = 0; n < 3; n++) begin
            #1 check_out("gap_idle", 3'b100, 1'b0, 8'hE1, 1'b0, 3'b100);
            step();
        end
        i_valid   = 3'b111;
        i_eop     = 3'b111;
        i_data[2] = 8'hE2;
        #1 check_out("gap_eop", 3'b100, 1'b1, 8'hE2, 1'b1, 3'b100);
        step();
        #1 check_out("gap_wrap", 3'b001, 1'b1, 8'hD0, 1'b1, 3'b001);

        // reset in the middle of an input-1 packet
        i_valid   = 3'b010;
        i_eop     = 3'b000;
        i_data[1] = 8'hF1;
        #1 check_out("rm_b1", 3'b010, 1'b1, 8'hF1, 1'b0, 3'b010);
        step();
        i_data[1] = 8'hF2;
        #1 check_out("rm_b2", 3'b010, 1'b1, 8'hF2, 1'b0, 3'b010);
        step();
        reset   = 1'b0;
        i_valid = 3'b111;
        #1 check_out("rm_rst", 3'b000, 1'b0, 8'h00, 1'b0, 3'b000);
        step();
        check_out("rm_rst2", 3'b000, 1'b0, 8'h00, 1'b0, 3'b000);
        reset = 1'b1;
        i_eop = 3'b111;
        #1 check_out("rm_post", 3'b001, 1'b1, 8'hD0, 1'b1, 3'b001);
        step();
        #1 check_out("rm_post2", 3'b010, 1'b1, 8'hF2, 1'b1, 3'b010);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
